nios2_mult_pipe: RTL and testbench
==================================

Name: nios2_mult_pipe

Overview:
- Parametrised pipelined integer multiplier for the Nios II execute/memory datapath.
- Next generation of the three-partial-product multiplier cell: computes the full 2*DATA_W-bit product internally instead of exporting raw 16x16 partial products.
- Adds per-operand signed/unsigned mode, configurable latency, a valid pipeline and a synchronous flush.
- Sits between the E-stage operand muxes and the M/W-stage result mux; the pipeline advances only on the stage enable.

Parameters:
DATA_W, 32, operand width; even, 8..64; split internally into two DATA_W/2 halves.
LATENCY, 2, enabled cycles from operand capture to result; legal 2..4. Stages beyond 2 are added as output delay registers.
SIGNED_EN, 1, 1 = sign inputs honoured; 0 = sign inputs ignored, all operands treated as unsigned.

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
en  in  1  pipeline advance; all stages hold when 0 (equivalent of M_en).
flush  in  1  synchronous kill of all in-flight valids.
in_valid  in  1  operands on src1/src2 are a real multiply.
src1  in  DATA_W  operand A.
src2  in  DATA_W  operand B.
src1_signed  in  1  A is two's complement.
src2_signed  in  1  B is two's complement.
out_valid  out  1  result_lo/result_hi hold a completed product.
result_lo  out  DATA_W  product bits [DATA_W-1:0] (MUL).
result_hi  out  DATA_W  product bits [2*DATA_W-1:DATA_W] (MULXSS/MULXSU/MULXUU).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Every pipeline register clears, including data, valid and the latched sign bits.
  - out_valid=0, result_lo=0, result_hi=0 immediately, without waiting for a clock edge.
  - Release is synchronous to clk; the first capture occurs on the first rising edge with en=1.
- Arithmetic:
  - {result_hi,result_lo} = A*B exactly, 2*DATA_W bits wide, with no truncation or saturation.
  - A and B are interpreted per src1_signed/src2_signed. Signed x unsigned is legal (MULXSU).
  - Implementation: four H x H unsigned partial products (ll, lh, hl, hh), H=DATA_W/2, plus a signed correction term.
  - Correction: subtract B<<DATA_W when A is signed and A[msb]=1; subtract A<<DATA_W when B is signed and B[msb]=1. Arithmetic is modulo 2^(2*DATA_W).
- Pipeline:
  - Stage 1, on clk with en=1: register the four partial products, the correction operands and in_valid.
  - Stage 2: register the summed 2W product.
  - Stages 3..LATENCY: plain delay registers.
  - Result for inputs captured at enabled edge N is visible after enabled edge N+LATENCY-1.
  - Example: LATENCY=2 → available the cycle after the second enabled edge.
  - Cycles with en=0 do not count toward latency.
- en=0:
  - Every register, including out_valid and results, holds its value.
  - Inputs presented while en=0 are not captured.
- flush=1 at a rising edge:
  - All valid bits clear (out_valid=0 the next cycle).
  - Data registers may keep stale values; no requirement is placed on result_* while out_valid=0.
  - flush overrides en.
  - The operand presented in the same cycle as flush is discarded.
- Throughput:
  - One new multiply accepted per enabled cycle; fully pipelined, with no back-pressure output.
  - Back-to-back operands with different sign modes are independent: sign bits travel with their data.
- Sign inputs when SIGNED_EN=0: ignored; the result equals the unsigned product.
- in_valid=0 with en=1: the bubble propagates and out_valid=0 at that slot. Data is still computed but is don't-care.
- Reset asserted mid-operation: all in-flight products are lost; there is no partial result.

Test Plan:
- DATA_W=32, LATENCY=2, unsigned, src1=0xFFFF_FFFF, src2=0xFFFF_FFFF, en=1 continuous → after 2 edges out_valid=1, result_hi=0xFFFF_FFFE, result_lo=0x0000_0001.
- Signed both sides, src1=0xFFFF_FFFF(-1), src2=0x0000_0005 → result_hi=0xFFFF_FFFF, result_lo=0xFFFF_FFFB. Repeat with src1_signed=1, src2_signed=0, src1=0x8000_0000, src2=0xFFFF_FFFF → result_hi=0x8000_0000, result_lo=0x8000_0000.
- Back-to-back stream of 8 operand pairs with alternating sign modes, en=1 → 8 consecutive out_valid cycles; every result matches the reference model in issue order.
- Stall: issue one op, then drop en for 3 cycles after the first edge → out_valid and results frozen during the stall; the result appears only after the second enabled edge; total latency 2 enabled edges.
- flush together with en=1 while 2 ops are in flight → out_valid=0 next cycle and stays 0 until a new op is issued. Assert reset_n=0 mid-stream → out_valid/result_lo/result_hi read 0 before the next clk edge.
- LATENCY=4 and DATA_W=16, random signed/unsigned operands, 1000 vectors with random en/in_valid → results bit-exact against the 32-bit reference product, each arriving exactly 4 enabled edges after capture.

Source files
------------

// File: rtl/nios2_mult_pipe_if.sv
// Operand/result bundle between the E-stage operand muxes and the multiplier pipe.
// The master drives operands and pipeline control; the slave returns the product.
interface nios2_mult_pipe_if #(
    parameter int DATA_W = 32
);
    logic              en;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              src1_signed;
    logic              src2_signed;
    logic              out_valid;
    logic [DATA_W-1:0] result_lo;
    logic [DATA_W-1:0] result_hi;

    modport master (
        output en, flush, in_valid, src1, src2, src1_signed, src2_signed,
        input  out_valid, result_lo, result_hi
    );

    modport slave (
        input  en, flush, in_valid, src1, src2, src1_signed, src2_signed,
        output out_valid, result_lo, result_hi
    );
endinterface

// File: rtl/nios2_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with per-operand sign mode, full 2*DATA_W product,
// stage-enable stalls and synchronous flush of in-flight valids.
module nios2_mult_pipe #(
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 2,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    nios2_mult_pipe_if.slave bus
);
    localparam int H  = DATA_W / 2;
    localparam int W2 = 2 * DATA_W;

    logic [DATA_W-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
    logic [DATA_W-1:0] corr_a_q, corr_a_d, corr_b_q, corr_b_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [W2-1:0]     prod_q [LATENCY-1];
    logic [W2-1:0]     prod_d [LATENCY-1];

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
    logic [W2-1:0]     sum;

    always_comb begin
        a_neg  = SIGNED_EN && bus.src1_signed && bus.src1[DATA_W-1];
        b_neg  = SIGNED_EN && bus.src2_signed && bus.src2[DATA_W-1];
        a_lo_x = {{H{1'b0}}, bus.src1[H-1:0]};
        a_hi_x = {{H{1'b0}}, bus.src1[DATA_W-1:H]};
        b_lo_x = {{H{1'b0}}, bus.src2[H-1:0]};
        b_hi_x = {{H{1'b0}}, bus.src2[DATA_W-1:H]};

        // Unsigned product of the raw bit patterns, then remove the 2^W weight of each
        // negative operand's sign bit: A*B - [A<0]*(B<<W) - [B<0]*(A<<W), mod 2^(2W).
        sum = {{DATA_W{1'b0}}, ll_q}
            + {{H{1'b0}}, lh_q, {H{1'b0}}}
            + {{H{1'b0}}, hl_q, {H{1'b0}}}
            + {hh_q, {DATA_W{1'b0}}}
            - {corr_a_q, {DATA_W{1'b0}}}
            - {corr_b_q, {DATA_W{1'b0}}};

        ll_d     = ll_q;
        lh_d     = lh_q;
        hl_d     = hl_q;
        hh_d     = hh_q;
        corr_a_d = corr_a_q;
        corr_b_d = corr_b_q;
        vld_d    = vld_q;
        prod_d   = prod_q;

        if (bus.en) begin
            ll_d     = a_lo_x * b_lo_x;
            lh_d     = a_lo_x * b_hi_x;
            hl_d     = a_hi_x * b_lo_x;
            hh_d     = a_hi_x * b_hi_x;
            corr_a_d = a_neg ? bus.src2 : '0;
            corr_b_d = b_neg ? bus.src1 : '0;
            vld_d    = {vld_q[LATENCY-2:0], bus.in_valid};
            prod_d[0] = sum;
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                prod_d[i] = prod_q[i-1];
            end
        end

        // Flush wins over en; data may go stale but nothing stays valid.
        if (bus.flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ll_q     <= '0;
            lh_q     <= '0;
            hl_q     <= '0;
            hh_q     <= '0;
            corr_a_q <= '0;
            corr_b_q <= '0;
            vld_q    <= '0;
            for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            ll_q     <= ll_d;
            lh_q     <= lh_d;
            hl_q     <= hl_d;
            hh_q     <= hh_d;
            corr_a_q <= corr_a_d;
            corr_b_q <= corr_b_d;
            vld_q    <= vld_d;
            prod_q   <= prod_d;
        end
    end

    assign bus.out_valid                   = vld_q[LATENCY-1];
    assign {bus.result_hi, bus.result_lo} = prod_q[LATENCY-2];
endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Scoreboard bench: 32-bit/L2 signed, 32-bit/L2 unsigned-only (shadowing the same inputs)
// and 16-bit/L4 instances checked against a longint reference product.
module tb_nios2_mult_pipe;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nios2_mult_pipe_if #(.DATA_W(32)) b32 ();
    nios2_mult_pipe_if #(.DATA_W(32)) bu ();
    nios2_mult_pipe_if #(.DATA_W(16)) b16 ();

    nios2_mult_pipe #(.DATA_W(32), .LATENCY(2), .SIGNED_EN(1'b1)) u32 (
        .clk(clk), .reset_n(reset_n), .bus(b32.slave));
    nios2_mult_pipe #(.DATA_W(32), .LATENCY(2), .SIGNED_EN(1'b0)) uus (
        .clk(clk), .reset_n(reset_n), .bus(bu.slave));
    nios2_mult_pipe #(.DATA_W(16), .LATENCY(4), .SIGNED_EN(1'b1)) u16 (
        .clk(clk), .reset_n(reset_n), .bus(b16.slave));

    assign bu.en          = b32.en;
    assign bu.flush       = b32.flush;
    assign bu.in_valid    = b32.in_valid;
    assign bu.src1        = b32.src1;
    assign bu.src2        = b32.src2;
    assign bu.src1_signed = b32.src1_signed;
    assign bu.src2_signed = b32.src2_signed;

    typedef struct {
        logic [63:0] v;
        logic [63:0] vu;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   cnt32 = 0, cnt16 = 0;
    bit   fresh32, flushed32, fresh16, flushed16;
    bit   want32, want16;
    int   errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sa, input bit sb, input int w);
        longint      ax, bx, p;
        logic [63:0] m;
        m  = (64'd1 << w) - 64'd1;
        ax = longint'({32'b0, a} & m);
        bx = longint'({32'b0, b} & m);
        if (sa && a[w-1]) ax = ax - longint'(64'd1 << w);
        if (sb && b[w-1]) bx = bx - longint'(64'd1 << w);
        p = ax * bx;
        if (w == 32) return 64'(p);
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Stimulus recorders: expectations are pushed at the capturing edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q32.delete();
            fresh32   = 1'b0;
            flushed32 = 1'b0;
        end else begin
            fresh32   = b32.en && !b32.flush;
            flushed32 = b32.flush;
            if (b32.flush) q32.delete();
            else if (b32.en) begin
                cnt32++;
                if (b32.in_valid)
                    q32.push_back('{ref_mul(b32.src1, b32.src2, b32.src1_signed, b32.src2_signed, 32),
                                    ref_mul(b32.src1, b32.src2, 1'b0, 1'b0, 32), cnt32 + 1});
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q16.delete();
            fresh16   = 1'b0;
            flushed16 = 1'b0;
        end else begin
            fresh16   = b16.en && !b16.flush;
            flushed16 = b16.flush;
            if (b16.flush) q16.delete();
            else if (b16.en) begin
                cnt16++;
                if (b16.in_valid)
                    q16.push_back('{ref_mul({16'b0, b16.src1}, {16'b0, b16.src2},
                                            b16.src1_signed, b16.src2_signed, 16), 64'd0, cnt16 + 3});
            end
        end
    end

    // Output monitors: compare on the falling edge after each advancing edge.
    always @(negedge clk) begin
        if (flushed32) begin
            check("flush_ov32", {63'b0, b32.out_valid}, 64'd0);
            check("flush_ovu", {63'b0, bu.out_valid}, 64'd0);
        end else if (fresh32) begin
            want32 = (q32.size() > 0) && (q32[0].due == cnt32);
            check("ov32", {63'b0, b32.out_valid}, {63'b0, want32});
            check("ovu", {63'b0, bu.out_valid}, {63'b0, want32});
            if (q32.size() > 0 && q32[0].due <= cnt32) begin
                e32 = q32.pop_front();
                if (want32) begin
                    check("res32", {b32.result_hi, b32.result_lo}, e32.v);
                    check("resu", {bu.result_hi, bu.result_lo}, e32.vu);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (flushed16) begin
            check("flush_ov16", {63'b0, b16.out_valid}, 64'd0);
        end else if (fresh16) begin
            want16 = (q16.size() > 0) && (q16[0].due == cnt16);
            check("ov16", {63'b0, b16.out_valid}, {63'b0, want16});
            if (q16.size() > 0 && q16[0].due <= cnt16) begin
                e16 = q16.pop_front();
                if (want16) check("res16", {32'b0, b16.result_hi, b16.result_lo}, e16.v);
            end
        end
    end

    task automatic set32(input bit en, input bit fl, input bit iv, input logic [31:0] a,
                         input logic [31:0] b, input bit sa, input bit sb);
        b32.en = en; b32.flush = fl; b32.in_valid = iv;
        b32.src1 = a; b32.src2 = b; b32.src1_signed = sa; b32.src2_signed = sb;
    endtask

    task automatic set16(input bit en, input bit fl, input bit iv, input logic [15:0] a,
                         input logic [15:0] b, input bit sa, input bit sb);
        b16.en = en; b16.flush = fl; b16.in_valid = iv;
        b16.src1 = a; b16.src2 = b; b16.src1_signed = sa; b16.src2_signed = sb;
    endtask

    task automatic cyc32(input bit en, input bit fl, input bit iv, input logic [31:0] a,
                         input logic [31:0] b, input bit sa, input bit sb);
        set32(en, fl, iv, a, b, sa, sb);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ov32"}, {63'b0, b32.out_valid}, 64'd0);
        check({tag, "_res32"}, {b32.result_hi, b32.result_lo}, 64'd0);
        check({tag, "_ovu"}, {63'b0, bu.out_valid}, 64'd0);
        check({tag, "_resu"}, {bu.result_hi, bu.result_lo}, 64'd0);
        check({tag, "_ov16"}, {63'b0, b16.out_valid}, 64'd0);
        check({tag, "_res16"}, {32'b0, b16.result_hi, b16.result_lo}, 64'd0);
    endtask

    logic [31:0] xa, xb, ya, yb;

    initial begin
        set32(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        set16(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // All-ones unsigned
        cyc32(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        cyc32(1, 0, 0, '0, '0, 0, 0);
        check("t_uu_ov", {63'b0, b32.out_valid}, 64'd1);
        check("t_uu", {b32.result_hi, b32.result_lo}, 64'hFFFF_FFFE_0000_0001);

        // -1 * 5 signed; unsigned-only instance must ignore the sign bits
        cyc32(1, 0, 1, 32'hFFFF_FFFF, 32'h0000_0005, 1, 1);
        cyc32(1, 0, 0, '0, '0, 0, 0);
        check("t_ss", {b32.result_hi, b32.result_lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        check("t_ss_u", {bu.result_hi, bu.result_lo}, 64'h0000_0004_FFFF_FFFB);

        // MULXSU: -2^31 * (2^32-1)
        cyc32(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        cyc32(1, 0, 0, '0, '0, 0, 0);
        check("t_su", {b32.result_hi, b32.result_lo}, 64'h8000_0000_8000_0000);
        check("t_su_u", {bu.result_hi, bu.result_lo}, 64'h7FFF_FFFF_8000_0000);

        // Back-to-back stream with rotating sign modes
        for (int i = 0; i < 8; i++)
            cyc32(1, 0, 1, $urandom, $urandom, 1'(i & 1), 1'((i >> 1) & 1));
        repeat (2) cyc32(1, 0, 0, '0, '0, 0, 0);

        // Stall: X visible, en low for 3 cycles with junk operands, then Y
        xa = 32'hDEAD_BEEF; xb = 32'h8765_4321;
        ya = 32'h7FFF_FFFF; yb = 32'h8000_0001;
        cyc32(1, 0, 1, xa, xb, 1, 1);
        cyc32(1, 0, 1, ya, yb, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc32(0, 0, 1, $urandom, $urandom, 1, 1);
            check("stall_ov", {63'b0, b32.out_valid}, 64'd1);
            check("stall_res", {b32.result_hi, b32.result_lo}, ref_mul(xa, xb, 1, 1, 32));
        end
        cyc32(1, 0, 0, '0, '0, 0, 0);
        check("stall_y_ov", {63'b0, b32.out_valid}, 64'd1);
        check("stall_y", {b32.result_hi, b32.result_lo}, ref_mul(ya, yb, 1, 0, 32));

        // Flush with ops in flight (operand presented with flush is dropped), then with en=0
        cyc32(1, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        cyc32(1, 0, 1, 32'h0000_0003, 32'h0000_0007, 0, 0);
        cyc32(1, 1, 1, 32'h0000_0011, 32'h0000_0013, 0, 0);
        repeat (3) cyc32(1, 0, 0, '0, '0, 0, 0);
        cyc32(1, 0, 1, 32'h0000_0021, 32'h0000_0023, 0, 0);
        cyc32(0, 1, 0, '0, '0, 0, 0);
        repeat (3) cyc32(1, 0, 0, '0, '0, 0, 0);

        // Random traffic on both widths concurrently
        for (int i = 0; i < 1000; i++) begin
            set32(1'($urandom_range(3) != 0), 1'($urandom_range(49) == 0), 1'($urandom_range(9) < 7),
                  $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            set16(1'($urandom_range(3) != 0), 1'($urandom_range(49) == 0), 1'($urandom_range(9) < 7),
                  16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            set32(1, 0, 0, '0, '0, 0, 0);
            set16(1, 0, 0, '0, '0, 0, 0);
            @(negedge clk);
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain16", 64'(q16.size()), 64'd0);

        // Asynchronous reset with valid results on the outputs
        for (int i = 0; i < 4; i++) begin
            set32(1, 0, 1, $urandom | 32'h1, $urandom | 32'h1, 0, 0);
            set16(1, 0, 1, 16'($urandom) | 16'h1, 16'($urandom) | 16'h1, 0, 0);
            @(negedge clk);
        end
        check("pre_rst_ov16", {63'b0, b16.out_valid}, 64'd1);
        set32(0, 0, 0, '0, '0, 0, 0);
        set16(0, 0, 0, '0, '0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_zero("arst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set32(1, 0, 0, '0, '0, 0, 0);
            set16(1, 0, 0, '0, '0, 0, 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
